// File: rtl/delayed_branch_resolver_pkg.sv
// Shared constants and types for the stage-3 delayed branch resolver.
package delayed_branch_resolver_pkg;

  localparam logic [2:0] CondNv = 3'd0;
  localparam logic [2:0] CondAl = 3'd1;
  localparam logic [2:0] CondEq = 3'd2;
  localparam logic [2:0] CondNe = 3'd3;
  localparam logic [2:0] CondLt = 3'd4;
  localparam logic [2:0] CondLe = 3'd5;
  localparam logic [2:0] CondGt = 3'd6;
  localparam logic [2:0] CondGe = 3'd7;

  localparam logic [7:0] HeadBranch = 8'b001_00_000;
  localparam logic [7:0] HeadHalt   = 8'b001_00_111;

  typedef enum logic [0:0] {
    StIdle,
    StInject
  } dbr_state_e;

endpackage

// File: rtl/delayed_branch_resolver_if.sv
// Bundle between the BGU/stage-3 datapath and the delayed branch resolver.
interface delayed_branch_resolver_if #(
  parameter int unsigned W_IR  = 16,
  parameter int unsigned W_CNT = 16
);
  logic             advance;
  logic             p0_valid_in;
  logic             p1_valid_in;
  logic [W_IR-1:0]  p0_delayed_B_in;
  logic [2:0]       p0_delayed_cond_in;
  logic [W_IR-1:0]  p1_delayed_B_in;
  logic [2:0]       p1_delayed_cond_in;
  logic             N;
  logic             V;
  logic             Z;
  logic             p0_do_delayed_B;
  logic             p1_do_delayed_B;
  logic [W_IR-1:0]  p0_IR_inject;
  logic [W_IR-1:0]  p1_IR_inject;
  logic             flush_out;
  logic [W_CNT-1:0] taken_cnt;
  logic [W_CNT-1:0] squash_cnt;

  modport master (
    output advance, p0_valid_in, p1_valid_in, p0_delayed_B_in, p0_delayed_cond_in,
           p1_delayed_B_in, p1_delayed_cond_in, N, V, Z,
    input  p0_do_delayed_B, p1_do_delayed_B, p0_IR_inject, p1_IR_inject, flush_out,
           taken_cnt, squash_cnt
  );

  modport slave (
    input  advance, p0_valid_in, p1_valid_in, p0_delayed_B_in, p0_delayed_cond_in,
           p1_delayed_B_in, p1_delayed_cond_in, N, V, Z,
    output p0_do_delayed_B, p1_do_delayed_B, p0_IR_inject, p1_IR_inject, flush_out,
           taken_cnt, squash_cnt
  );
endinterface

// File: rtl/delayed_branch_resolver_cond_eval.sv
// Evaluates a 3-bit branch condition code against the N/V/Z flags.
module cond_eval
  import delayed_branch_resolver_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       n,
  input  logic       v,
  input  logic       z,
  output logic       take
);

  logic lt;
  assign lt = n ^ v;

  always_comb begin
    take = 1'b0;
    unique case (cond)
      CondNv: take = 1'b0;
      CondAl: take = 1'b1;
      CondEq: take = z;
      CondNe: take = ~z;
      CondLt: take = lt;
      CondLe: take = lt | z;
      CondGt: take = ~(lt | z);
      CondGe: take = ~lt;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/delayed_branch_resolver.sv
// Stage-3 delayed branch resolver: two-slot pipeline, condition check, flush and re-inject.
// Optional statistics counters are built when DBR_STATS_EN is defined.
module delayed_branch_resolver
  import delayed_branch_resolver_pkg::*;
#(
  parameter int unsigned W_IR  = 16,
  parameter int unsigned W_CNT = 16
) (
  input logic                    clk,
  input logic                    rst,
  delayed_branch_resolver_if.slave bus
);

  logic [1:0]      s2_valid_q, s3_valid_q;
  logic [W_IR-1:0] s2_word_q [2];
  logic [W_IR-1:0] s3_word_q [2];
  logic [2:0]      s2_cond_q [2];
  logic [2:0]      s3_cond_q [2];

  logic            sel_q;
  logic [W_IR-1:0] word_q;

  dbr_state_e state_q, state_d;

  logic take_p0, take_p1;
  logic eval, fire_p0, fire_p1, fire_any;

  cond_eval u_cond_p0 (
    .cond (s3_cond_q[0]),
    .n    (bus.N),
    .v    (bus.V),
    .z    (bus.Z),
    .take (take_p0)
  );

  cond_eval u_cond_p1 (
    .cond (s3_cond_q[1]),
    .n    (bus.N),
    .v    (bus.V),
    .z    (bus.Z),
    .take (take_p1)
  );

  // Flags are only meaningful while IDLE and advancing; reset suppresses a stale fire.
  assign eval     = (state_q == StIdle) && bus.advance && !rst;
  assign fire_p0  = eval && s3_valid_q[0] && take_p0;
  assign fire_p1  = eval && s3_valid_q[1] && take_p1 && !fire_p0;
  assign fire_any = fire_p0 | fire_p1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fire_any) state_d = StInject;
      StInject: if (bus.advance) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.p0_do_delayed_B = 1'b0;
    bus.p1_do_delayed_B = 1'b0;
    bus.p0_IR_inject    = '0;
    bus.p1_IR_inject    = '0;
    bus.flush_out       = fire_any;
    if (state_q == StInject) begin
      bus.flush_out = 1'b1;
      if (sel_q) begin
        bus.p1_do_delayed_B = 1'b1;
        bus.p1_IR_inject    = word_q;
      end else begin
        bus.p0_do_delayed_B = 1'b1;
        bus.p0_IR_inject    = word_q;
      end
    end
  end

  // Slots only move while IDLE; a fire discards everything in flight, including this cycle's inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= '0;
      s3_valid_q <= '0;
      s2_word_q  <= '{default: '0};
      s3_word_q  <= '{default: '0};
      s2_cond_q  <= '{default: '0};
      s3_cond_q  <= '{default: '0};
      sel_q      <= 1'b0;
      word_q     <= '0;
    end else if (state_q == StIdle && bus.advance) begin
      if (fire_any) begin
        s2_valid_q <= '0;
        s3_valid_q <= '0;
        sel_q      <= ~fire_p0;
        word_q     <= fire_p0 ? s3_word_q[0] : s3_word_q[1];
      end else begin
        s2_valid_q   <= {bus.p1_valid_in, bus.p0_valid_in};
        s2_word_q[0] <= bus.p0_delayed_B_in;
        s2_word_q[1] <= bus.p1_delayed_B_in;
        s2_cond_q[0] <= bus.p0_delayed_cond_in;
        s2_cond_q[1] <= bus.p1_delayed_cond_in;
        s3_valid_q   <= s2_valid_q;
        s3_word_q    <= s2_word_q;
        s3_cond_q    <= s2_cond_q;
      end
    end
  end

`ifdef DBR_STATS_EN
  logic [W_CNT-1:0] taken_cnt_q, squash_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (fire_any)                   taken_cnt_q  <= taken_cnt_q + 1'b1;
      if (fire_p0 && s3_valid_q[1])   squash_cnt_q <= squash_cnt_q + 1'b1;
    end
  end

  assign bus.taken_cnt  = taken_cnt_q;
  assign bus.squash_cnt = squash_cnt_q;
`else
  assign bus.taken_cnt  = '0;
  assign bus.squash_cnt = '0;
`endif

endmodule

// File: doc/delayed_branch_resolver.md
# delayed_branch_resolver

- Stage-3 counterpart of the branch generation unit: it consumes the delayed branch words and condition codes the BGU emits for lanes p0/p1.
- It carries them through two pipeline slots and evaluates each condition against the N/V/Z flags.
- When a condition holds, it flushes the younger work and re-injects the delayed word into the BGU as an absolute-destination branch (`px_do_delayed_B`); the BGU then redirects the PC or raises HALT.

## Interface
- Parameters:
  - `W_IR`, default 16, instruction word width.
  - `W_CNT`, default 16, width of the statistics counters.
- Ports:
  - `clk` in 1: clock.
  - `rst` in 1: reset, synchronous, active-high.
  - `advance` in 1: pipeline advance; the same strobe as the BGU fetch_next.
  - `p0_valid_in` in 1: the p0 delayed word is meaningful (BGU reported a branch/HALT in p0).
  - `p1_valid_in` in 1: the p1 delayed word is meaningful.
  - `p0_delayed_B_in` in W_IR: p0 delayed word. [15:8] is the head (001_00_000 branch, 001_00_111 HALT_immediately); [7:0] is the absolute destination.
  - `p0_delayed_cond_in` in 3: p0 condition code.
  - `p1_delayed_B_in` in W_IR: same as p0, for lane p1.
  - `p1_delayed_cond_in` in 3: same as p0, for lane p1.
  - `N`, `V`, `Z` in 1 each: ALU flags, valid for the stage-3 instruction pair.
  - `p0_do_delayed_B` out 1: p0 injects a delayed branch into the BGU.
  - `p1_do_delayed_B` out 1: p1 injects a delayed branch into the BGU.
  - `p0_IR_inject` out W_IR: word driven into the p0 fetch path while injecting, else 0.
  - `p1_IR_inject` out W_IR: same as p0, for lane p1.
  - `flush_out` out 1: kill the stage-1/2 instructions this cycle.
  - `taken_cnt` out W_CNT: number of delayed branches fired (only with DBR_STATS_EN).
  - `squash_cnt` out W_CNT: number of p1 entries squashed by a p0 fire (only with DBR_STATS_EN).

## Operation
- **Condition codes:** NV=0 false; AL=1 true; EQ=2 Z; NE=3 !Z; LT=4 N^V; LE=5 (N^V)|Z; GT=6 !((N^V)|Z); GE=7 !(N^V).
- **Slots:** S2 and S3 each hold {valid, word, cond} per lane.
  - On `advance`: S2 <= inputs; S3 <= S2.
  - With `advance` low, both slots hold.
- **fire_px** = S3.px.valid && cond(S3.px.cond, N, V, Z).
  - p0 is older than p1. If fire_p0, p1 is squashed regardless of its own condition.
  - A HALT word (head 001_00_111, cond AL) fires like any other delayed branch; the BGU performs the halt.
- **FSM states:** IDLE, INJECT.
  - IDLE: combinational evaluation only while `advance`=1. On fire, on that clock edge:
    - latch the lane select and the word;
    - clear all S2/S3 valids;
    - go to INJECT.
  - `flush_out` is asserted combinationally in the firing cycle.
  - INJECT:
    - assert `px_do_delayed_B`=1 for the selected lane only;
    - drive `px_IR_inject` = latched word, and 0 for the other lane;
    - assert `flush_out`=1;
    - capture nothing into S2.
    - Leave INJECT to IDLE on the first cycle where `advance`=1 (BGU accepted the word); the injected word is not captured.
  - While `advance`=0 in INJECT: hold all outputs stable.
- Inputs arriving with `valid`=0 never fire, whatever the cond field holds.

## Timing
- **Reset values:**
  - outputs: all do_delayed_B=0, IR_inject=0, flush_out=0, counters=0;
  - internal: all slot valids=0; FSM in IDLE.
- **Latency:**
  - A word captured on advance edge k resolves in the cycle after edge k+1, i.e. two advances after capture.
  - Injection is visible for at least one cycle after the firing edge.
- **Flags:** N/V/Z are sampled only in the cycle fire is evaluated (IDLE, advance=1).
- **Simultaneous events:**
  - fire_p0 && fire_p1: p0 wins and p1 is counted as squashed.
  - fire in the same cycle that new inputs are valid: the new inputs are discarded.
- **Reset mid-INJECT:** return to IDLE next edge with all outputs 0; no partial injection.
- **Counters:** wrap at 2^W_CNT.

## Configuration
- `DBR_STATS_EN` defined: `taken_cnt` increments on every IDLE->INJECT transition; `squash_cnt` increments when S3.p1.valid && fire_p0.
- Undefined: the counter registers are not built and both outputs are tied to 0.

## Structure
- Shared package holds:
  - the cond localparams NV..GE;
  - the HALT head constant 8'b001_00_111 and the branch head 8'b001_00_000;
  - the FSM state enum.
- One sub-module, `cond_eval` (3-bit cond + N/V/Z -> take), is instantiated once per lane.

## Test plan
- **EQ fire:** p0 valid, word 0x2012, cond EQ; two advances with Z=1 -> flush_out=1 in the fire cycle; next cycle p0_do_delayed_B=1 and p0_IR_inject=0x2012; IDLE after the next advance.
- **No fire:** same stimulus with Z=0 -> no flush, do_delayed_B stays 0, slot drains.
- **Priority:** p0 cond LT with N=1, V=0 and p1 cond AL both valid -> only p0 injects; p1 never injects; squash_cnt=1.
- **HALT:** p1 word 0x2745, cond AL -> p1_do_delayed_B=1 with p1_IR_inject=0x2745.
- **Stall:** advance held low 3 cycles while in INJECT -> outputs stable, then release on the advance edge.
- **Reset:** rst asserted in the INJECT cycle -> the following cycle shows all outputs 0 and no fire from stale slots.
